// File: rtl/twisted_ring_counter.sv
// ---------------------------------------------------------------------------
// TwistedRingCounter
//
// Purpose:
//   WIDTH-stage shift counter that runs either as a Johnson (twisted ring)
//   counter with 2*WIDTH states or as a one-hot ring counter with WIDTH
//   states. It counts up or down and can be loaded synchronously. It also
//   decodes the current pattern into a count index, detects illegal patterns
//   and flags the terminal count.
//
// Ports:
//   clk     in   clock, all state changes on the rising edge
//   r       in   synchronous active-high reset (loads the seed of mode)
//   en      in   count enable
//   up      in   direction, 1 = up, 0 = down
//   mode    in   0 = Johnson, 1 = ring (one-hot)
//   ld      in   synchronous load strobe
//   ld_val  in   value written on load (WIDTH bits)
//   out     out  counter register, bit 0 is the input stage
//   idx     out  decoded count index (0 when the pattern is illegal)
//   tc      out  terminal count, combinational
//   err     out  illegal-pattern flag, combinational from out
// ---------------------------------------------------------------------------
module twisted_ring_counter #(
    parameter int WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               r,
    input  logic                               en,
    input  logic                               up,
    input  logic                               mode,
    input  logic                               ld,
    input  logic [WIDTH-1:0]                   ld_val,
    output logic [WIDTH-1:0]                   out,
    output logic [$clog2(2*WIDTH)-1:0]         idx,
    output logic                               tc,
    output logic                               err
);

    localparam int IW = $clog2(2*WIDTH);

    // Highest index in each mode; the terminal count compares against these.
    localparam logic [IW-1:0] JOHNSON_MAX = IW'(2*WIDTH - 1);
    localparam logic [IW-1:0] RING_MAX    = IW'(WIDTH - 1);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             mode_q;

    logic [IW-1:0]    onesCnt;
    logic [IW-1:0]    edgeCnt;
    logic [IW-1:0]    setPos;
    logic             legal;
    logic [IW-1:0]    rawIdx;
    logic [WIDTH-1:0] shifted;

    // Seed pattern: all zeros for Johnson, a single one in bit 0 for ring.
    function automatic logic [WIDTH-1:0] seedOf(input logic m);
        return m ? WIDTH'(1) : '0;
    endfunction

    // Pattern statistics used by both decoders: number of ones, number of
    // adjacent-bit transitions, and the position of the (highest) set bit.
    always_comb begin
        onesCnt = '0;
        edgeCnt = '0;
        setPos  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (out_q[i]) begin
                onesCnt = onesCnt + IW'(1);
                setPos  = IW'(i);
            end
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (out_q[i] != out_q[i+1]) begin
                edgeCnt = edgeCnt + IW'(1);
            end
        end
    end

    // Decode legality and index for the mode the register currently holds.
    // A Johnson pattern is legal exactly when it has at most one transition
    // between neighbouring bits. With bit 0 set (or all zeros) it is the
    // "k ones from bit 0" form and the index is the popcount; otherwise it is
    // the "j zeros from bit 0" form and the index is WIDTH + j, which equals
    // 2*WIDTH - popcount (modulo arithmetic in IW bits gives the right value).
    always_comb begin
        legal  = 1'b0;
        rawIdx = '0;
        if (mode_q) begin
            legal  = (onesCnt == IW'(1));
            rawIdx = setPos;
        end else begin
            legal = (edgeCnt <= IW'(1));
            if (out_q[0] || (onesCnt == '0)) begin
                rawIdx = onesCnt;
            end else begin
                rawIdx = IW'(2*WIDTH) - onesCnt;
            end
        end
    end

    assign err = ~legal;
    assign idx = err ? '0 : rawIdx;

    // Terminal count is only meaningful when a real shift is about to happen
    // in the current mode, so a load or a pending mode change suppresses it.
    assign tc = en & ~err & ~ld & (mode == mode_q) &
                ((up & (idx == (mode_q ? RING_MAX : JOHNSON_MAX))) |
                 (~up & (idx == '0)));

    // One step in the current direction. The Johnson feedback inverts the
    // bit that wraps around; the ring rotates it unchanged.
    always_comb begin
        shifted = out_q;
        if (up) begin
            shifted = {out_q[WIDTH-2:0], (mode_q ? out_q[WIDTH-1] : ~out_q[WIDTH-1])};
        end else begin
            shifted = {(mode_q ? out_q[0] : ~out_q[0]), out_q[WIDTH-1:1]};
        end
    end

    // Next-state selection below reset: a mode change reseeds immediately,
    // then load, then a count that recovers from an illegal pattern by
    // reseeding, then a normal shift, otherwise hold.
    always_comb begin
        out_d = out_q;
        if (mode != mode_q) begin
            out_d = seedOf(mode);
        end else if (ld) begin
            out_d = ld_val;
        end else if (en && err) begin
            out_d = seedOf(mode);
        end else if (en) begin
            out_d = shifted;
        end
    end

    // State registers. Reset overrides everything and reseeds for the
    // requested mode; mode_q simply tracks mode every cycle.
    always_ff @(posedge clk) begin
        if (r) begin
            out_q <= seedOf(mode);
        end else begin
            out_q <= out_d;
        end
        mode_q <= mode;
    end

    assign out = out_q;

endmodule

// File: tb/tb_twisted_ring_counter.sv
// ---------------------------------------------------------------------------
// TbTwistedRingCounter
//
// Purpose:
//   Directed self-checking bench for twisted_ring_counter at WIDTH=8.
//   Inputs are changed 1 time unit after a rising edge; registered outputs
//   are sampled 1 time unit after the edge and tc is sampled once the new
//   inputs have settled, before the next edge.
// ---------------------------------------------------------------------------
module tb_twisted_ring_counter;

    localparam int WIDTH = 8;
    localparam int IW    = $clog2(2*WIDTH);

    logic             clk;
    logic             r;
    logic             en;
    logic             up;
    logic             mode;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] out;
    logic [IW-1:0]    idx;
    logic             tc;
    logic             err;

    int checks;
    int failures;

    twisted_ring_counter #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .r      (r),
        .en     (en),
        .up     (up),
        .mode   (mode),
        .ld     (ld),
        .ld_val (ld_val),
        .out    (out),
        .idx    (idx),
        .tc     (tc),
        .err    (err)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one set of inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic rV, input logic enV, input logic upV,
                                 input logic modeV, input logic ldV,
                                 input logic [WIDTH-1:0] ldValV);
        r      = rV;
        en     = enV;
        up     = upV;
        mode   = modeV;
        ld     = ldV;
        ld_val = ldValV;
        #1;
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    logic [7:0] johnsonUp [16];

    // Directed sequence covering reset, both modes, both directions, mode
    // change, illegal load recovery and control priorities.
    initial begin
        checks   = 0;
        failures = 0;
        johnsonUp = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                      8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

        // Reset into Johnson mode.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        checkOutput("rst_j_out", 32'(out), 32'h00);
        checkOutput("rst_j_idx", 32'(idx), 32'd0);
        checkOutput("rst_j_err", 32'(err), 32'd0);

        // Reset into ring mode.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        tick();
        checkOutput("rst_r_out", 32'(out), 32'h01);
        checkOutput("rst_r_idx", 32'(idx), 32'd0);

        // Johnson up, full 16-state cycle.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        for (int n = 0; n < 16; n++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
            checkOutput($sformatf("jup_tc%0d", n), 32'(tc), (n == 15) ? 32'd1 : 32'd0);
            tick();
            checkOutput($sformatf("jup_out%0d", n), 32'(out), 32'(johnsonUp[n]));
            checkOutput($sformatf("jup_idx%0d", n), 32'(idx), 32'((n + 1) % 16));
            checkOutput($sformatf("jup_err%0d", n), 32'(err), 32'd0);
        end

        // Johnson down from zero wraps to idx 15.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("jdn_tc_at0", 32'(tc), 32'd1);
        tick();
        checkOutput("jdn_out", 32'(out), 32'h80);
        checkOutput("jdn_idx", 32'(idx), 32'd15);
        checkOutput("jdn_tc_at15", 32'(tc), 32'd0);

        // Hold with en low.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        checkOutput("hold_out", 32'(out), 32'h80);

        // Mode change mid-count: Johnson 0x07, then switch to ring.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
            tick();
        end
        checkOutput("mc_pre_out", 32'(out), 32'h07);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("mc_tc_pending", 32'(tc), 32'd0);
        tick();
        checkOutput("mc_seed_out", 32'(out), 32'h01);
        for (int n = 1; n < 8; n++) begin
            tick();
            checkOutput($sformatf("rup_out%0d", n), 32'(out), 32'(8'h01 << n));
            checkOutput($sformatf("rup_idx%0d", n), 32'(idx), 32'(n));
        end
        checkOutput("rup_tc_at7", 32'(tc), 32'd1);
        tick();
        checkOutput("rup_wrap_out", 32'(out), 32'h01);

        // Ring down from bit 0 rotates to bit 7.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("rdn_tc_at0", 32'(tc), 32'd1);
        tick();
        checkOutput("rdn_out", 32'(out), 32'h80);
        checkOutput("rdn_idx", 32'(idx), 32'd7);

        // Illegal load in Johnson mode, then recovery on the next count.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h05);
        tick();
        checkOutput("ill_out", 32'(out), 32'h05);
        checkOutput("ill_err", 32'(err), 32'd1);
        checkOutput("ill_idx", 32'(idx), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("ill_tc", 32'(tc), 32'd0);
        tick();
        checkOutput("rec_out", 32'(out), 32'h00);
        checkOutput("rec_err", 32'(err), 32'd0);

        // Load beats enable: value taken unshifted.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3F);
        checkOutput("ld_tc_block", 32'(tc), 32'd0);
        tick();
        checkOutput("lden_out", 32'(out), 32'h3F);
        checkOutput("lden_idx", 32'(idx), 32'd6);

        // Zeros-form Johnson index after a load.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hF8);
        tick();
        checkOutput("ldz_idx", 32'(idx), 32'd11);

        // Reset beats load.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAA);
        tick();
        checkOutput("rstld_out", 32'(out), 32'h00);
        checkOutput("rstld_err", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/twisted_ring_counter.md
TWISTED_RING_COUNTER -- requirements
Module: twisted_ring_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of counter stages; legal values are 2 to 32.
REQ-002 The block SHALL have localparam IW = clog2(2*WIDTH), the width of the index output.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port r, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port up, input, 1 bit: direction; 1 = up, 0 = down.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = Johnson (twisted ring), 1 = ring (one-hot).
REQ-008 The block SHALL have port ld, input, 1 bit: synchronous load strobe.
REQ-009 The block SHALL have port ld_val, input, WIDTH bits: the value written on load.
REQ-010 The block SHALL have port out, output, WIDTH bits: the counter register; bit 0 is the input stage.
REQ-011 The block SHALL have port idx, output, IW bits: the decoded count index.
REQ-012 The block SHALL have port tc, output, 1 bit: terminal count, combinational.
REQ-013 The block SHALL have port err, output, 1 bit: illegal-pattern flag, combinational from out.

Function
REQ-014 Johnson up SHALL set out[0] <= ~out[WIDTH-1] and out[i] <= out[i-1].
REQ-015 Johnson down SHALL set out[WIDTH-1] <= ~out[0] and out[i] <= out[i+1].
REQ-016 Ring up SHALL set out[0] <= out[WIDTH-1] and out[i] <= out[i-1]; ring down is the mirror rotation.
REQ-017 The seed value SHALL be all zeros in Johnson mode and 1 in bit 0 only in ring mode.
REQ-018 The block SHALL keep a registered copy mode_q of mode; mode_q is loaded every cycle.
REQ-019 Next-state priority SHALL be:
- r, which loads the seed of mode;
- mode != mode_q, which loads the seed of the new mode regardless of en or ld;
- ld, which loads ld_val unmodified;
- en with err=1, which loads the seed of mode;
- en, which shifts per REQ-014..016;
- otherwise hold.
REQ-020 Johnson legal patterns SHALL be exactly the 2*WIDTH patterns of the form "k contiguous ones from bit 0" (k = 0..WIDTH) or "j contiguous zeros from bit 0, ones above" (j = 1..WIDTH-1).
REQ-021 Ring legal patterns SHALL be exactly one bit set.
REQ-022 err SHALL be 1 whenever out is not a legal pattern for mode_q.
REQ-023 In Johnson mode, idx SHALL be k for the k-ones form and WIDTH+j for the j-zeros form.
REQ-024 In ring mode, idx SHALL be the position of the set bit.
REQ-025 idx SHALL be 0 whenever err=1.
REQ-026 tc SHALL be en & ~err & ~ld & (mode == mode_q) & ((up & idx == MAX) | (~up & idx == 0)), where MAX = 2*WIDTH-1 in Johnson mode and WIDTH-1 in ring mode.
REQ-027 Wrap-around SHALL be natural: up from MAX gives idx 0, and down from 0 gives MAX; no extra cycle is inserted.
REQ-028 A change of up SHALL take effect on the same edge with no state disturbance.
REQ-029 The latency from any control input to out SHALL be one clock.

Reset
REQ-030 While r=1 at a clock edge, out SHALL become the seed of mode and mode_q SHALL become mode, overriding ld, en and any pending mode change.
REQ-031 After reset, idx SHALL be 0 and err SHALL be 0.
REQ-032 After reset, tc SHALL follow REQ-026; e.g. en=1, up=0 gives tc=1 at idx 0.
REQ-033 Reset asserted mid-count SHALL take effect at the next edge without completing the shift.
REQ-034 There SHALL be no asynchronous reset path.

Verification (WIDTH=8)
REQ-035 Reset with mode=0 -> out=0x00, idx=0, err=0; with mode=1 -> out=0x01.
REQ-036 Johnson, up=1, 16 enabled cycles from 0x00:
- out SHALL step 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00;
- idx SHALL step 1..15,0;
- tc SHALL be high only while idx=15.
REQ-037 Johnson, up=0, from 0x00 -> out=0x80, idx=15; tc SHALL be high during the idx=0 cycle.
REQ-038 Mode change: toggle mode 0->1 mid-count with en=1 -> next out=0x01, then 0x02, 0x04; tc SHALL be high at 0x80 with up=1.
REQ-039 Illegal load: Johnson, ld=1, ld_val=0x05 -> out=0x05, err=1, idx=0, tc=0; next en cycle -> out=0x00, err=0.
REQ-040 ld=1 together with en=1 -> ld_val loaded with no shift; r=1 together with ld=1 -> seed loaded.
